weight_prefetch_v2: RTL and testbench



---
 rtl/weight_prefetch_v2_if.sv | 35 +++
 rtl/weight_prefetch_v2.sv | 216 +++++++++++++++++++++
 tb/tb_weight_prefetch_v2.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/weight_prefetch_v2_if.sv
// Bundle of the DDR burst-read port and the weight-buffer consumer port.
//   master : the prefetcher (drives rd_burst_req/addr/len and the o_* buffer outputs)
//   slave  : the environment (DDR arbiter + compute controller)
interface weight_prefetch_v2_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned LEN_WIDTH  = 10,
  parameter int unsigned SEG_W      = 2
);
  logic [DATA_WIDTH-1:0] rd_burst_data;
  logic [ADDR_SIZE-1:0]  rd_burst_addr;
  logic [LEN_WIDTH-1:0]  rd_burst_len;
  logic                  rd_burst_req;
  logic                  rd_burst_valid;
  logic                  rd_burst_finish;
  logic [DATA_WIDTH-1:0] o_weight_out;
  logic [SEG_W-1:0]      o_weight_seg;
  logic                  o_weight_last;
  logic                  i_weight_valid;
  logic                  o_weight_ready;
  logic                  load_w_finish;
  logic                  o_err;

  modport master (
    input  rd_burst_data, rd_burst_valid, rd_burst_finish, i_weight_valid, load_w_finish,
    output rd_burst_addr, rd_burst_len, rd_burst_req,
    output o_weight_out, o_weight_seg, o_weight_last, o_weight_ready, o_err
  );

  modport slave (
    output rd_burst_data, rd_burst_valid, rd_burst_finish, i_weight_valid, load_w_finish,
    input  rd_burst_addr, rd_burst_len, rd_burst_req,
    input  o_weight_out, o_weight_seg, o_weight_last, o_weight_ready, o_err
  );
endinterface

// File: rtl/weight_prefetch_v2.sv
// Weight prefetcher: walks a table of DDR weight segments in fixed-length bursts,
// replays each segment SEG_REPEAT times, and buffers {data, seg, last} in a FWFT FIFO.
// Ports:
//   s_clk, s_rst : clock, synchronous active-high reset
//   bus (master) : rd_burst_* DDR read port, o_weight_* / i_weight_valid buffer port,
//                  load_w_finish flush pulse, o_err sticky underflow/overflow flag
module weight_prefetch_v2 #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_SIZE    = 32,
  parameter int unsigned LEN_WIDTH    = 10,
  parameter int unsigned BURST_LEN    = 32,
  parameter int unsigned FIFO_DEPTH   = 512,
  parameter int unsigned READY_THRESH = 64,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
  parameter int unsigned SEG_NUM      = 4,
  parameter logic [SEG_NUM*ADDR_SIZE-1:0] SEG_BYTES  = {SEG_NUM{ADDR_SIZE'(1024)}},
  parameter logic [SEG_NUM*4-1:0]         SEG_REPEAT = {SEG_NUM{4'd1}}
) (
  input logic s_clk,
  input logic s_rst,
  weight_prefetch_v2_if.master bus
);

  localparam int unsigned SEG_W       = (SEG_NUM > 1) ? $clog2(SEG_NUM) : 1;
  localparam int unsigned BURST_BYTES = BURST_LEN * DATA_WIDTH / 8;
  localparam int unsigned PTR_W       = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W       = PTR_W + 1;
  localparam int unsigned BEAT_W      = $clog2(BURST_LEN + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_FLUSH = 2'd3;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [SEG_W-1:0]      seg;
    logic                  last;
  } entry_t;

  // Byte address of segment s: base plus the sizes of all earlier segments.
  function automatic logic [ADDR_SIZE-1:0] start_of(input int unsigned s);
    logic [ADDR_SIZE-1:0] a;
    a = BASE_ADDR;
    for (int unsigned i = 0; i < s; i++) a += SEG_BYTES[i*ADDR_SIZE +: ADDR_SIZE];
    return a;
  endfunction

  // Per-segment constant tables: start address, address of the final burst, pass count.
  logic [ADDR_SIZE-1:0] seg_start [SEG_NUM];
  logic [ADDR_SIZE-1:0] seg_end   [SEG_NUM];
  logic [3:0]           seg_rep   [SEG_NUM];

  for (genvar g = 0; g < SEG_NUM; g++) begin : g_seg
    localparam logic [ADDR_SIZE-1:0] START = start_of(g);
    assign seg_start[g] = START;
    assign seg_end[g]   = START + SEG_BYTES[g*ADDR_SIZE +: ADDR_SIZE] - ADDR_SIZE'(BURST_BYTES);
    assign seg_rep[g]   = SEG_REPEAT[g*4 +: 4];
  end

  logic [1:0]           state_q, state_d;
  logic                 req_q, req_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [SEG_W-1:0]     seg_q, seg_d, seg_nxt;
  logic [3:0]           pass_q, pass_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 err_q, err_d;
  logic                 ready_q, ready_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 wr_en, rd_en, clr, last_burst, space_ok;
  entry_t               wr_entry, head;
  entry_t               mem_q [FIFO_DEPTH];

  assign head       = mem_q[rd_ptr_q];
  assign last_burst = (addr_q == seg_end[seg_q]);
  assign space_ok   = (32'(count_q) + BURST_LEN) <= FIFO_DEPTH;
  assign seg_nxt    = (seg_q == SEG_W'(SEG_NUM - 1)) ? '0 : seg_q + SEG_W'(1);

  // Next-state, pointer walk and buffer control.
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    addr_d   = addr_q;
    seg_d    = seg_q;
    pass_d   = pass_q;
    beat_d   = beat_q;
    err_d    = err_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    clr      = 1'b0;
    wr_entry = '{data: bus.rd_burst_data, seg: seg_q,
                 last: last_burst && (beat_q == BEAT_W'(BURST_LEN - 1))};

    // Popping an empty buffer is ignored but flagged.
    if (bus.i_weight_valid) begin
      if (count_q == '0) err_d = 1'b1;
      else               rd_en = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Data with no burst outstanding (e.g. stale beats after reset).
        if (bus.rd_burst_valid) err_d = 1'b1;
        if (bus.load_w_finish) begin
          state_d = ST_FLUSH;
        end else if (space_ok) begin
          state_d = ST_BUSY;
          req_d   = 1'b1;
          beat_d  = '0;
        end
      end
      ST_BUSY: begin
        if (bus.rd_burst_valid) begin
          if (beat_q < BEAT_W'(BURST_LEN)) begin
            wr_en  = 1'b1;
            beat_d = beat_q + BEAT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        if (bus.rd_burst_finish) begin
          req_d = 1'b0;
          if (bus.load_w_finish) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
            if (!last_burst) begin
              addr_d = addr_q + ADDR_SIZE'(BURST_BYTES);
            end else if (pass_q < (seg_rep[seg_q] - 4'd1)) begin
              pass_d = pass_q + 4'd1;
              addr_d = seg_start[seg_q];
            end else begin
              pass_d = '0;
              seg_d  = seg_nxt;
              addr_d = seg_start[seg_nxt];
            end
          end
        end else if (bus.load_w_finish) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Let the in-flight burst complete without storing it.
        if (bus.rd_burst_finish) begin
          req_d   = 1'b0;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        clr     = 1'b1;
        state_d = ST_IDLE;
        addr_d  = BASE_ADDR;
        seg_d   = '0;
        pass_d  = '0;
        err_d   = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
      rd_ptr_d = rd_ptr_q + PTR_W'(rd_en);
      count_d  = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
    ready_d = 32'(count_d) >= READY_THRESH;
  end

  // State and control registers.
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      addr_q   <= BASE_ADDR;
      seg_q    <= '0;
      pass_q   <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      seg_q    <= seg_d;
      pass_q   <= pass_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Buffer storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge s_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign bus.rd_burst_req   = req_q;
  assign bus.rd_burst_addr  = addr_q;
  assign bus.rd_burst_len   = LEN_WIDTH'(BURST_LEN);
  assign bus.o_weight_out   = (count_q != '0) ? head.data : '0;
  assign bus.o_weight_seg   = (count_q != '0) ? head.seg  : '0;
  assign bus.o_weight_last  = (count_q != '0) ? head.last : 1'b0;
  assign bus.o_weight_ready = ready_q;
  assign bus.o_err          = err_q;

endmodule

// File: tb/tb_weight_prefetch_v2.sv
// Scoreboard bench for weight_prefetch_v2 with a small directed DDR burst model.
module tb_weight_prefetch_v2;

  typedef struct packed {
    logic [63:0] data;
    logic        seg;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  weight_prefetch_v2_if #(.DATA_WIDTH(64), .ADDR_SIZE(32), .LEN_WIDTH(10), .SEG_W(1)) bus ();

  weight_prefetch_v2 #(
    .DATA_WIDTH(64), .ADDR_SIZE(32), .LEN_WIDTH(10), .BURST_LEN(4), .FIFO_DEPTH(16),
    .READY_THRESH(4), .BASE_ADDR(32'h1000), .SEG_NUM(2),
    .SEG_BYTES({32'd32, 32'd64}), .SEG_REPEAT({4'd1, 4'd2})
  ) dut (
    .s_clk(clk),
    .s_rst(rst),
    .bus(bus)
  );

  word_t       exp_word [$];
  logic [31:0] exp_addr [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        req_prev = 1'b0;
  word_t       mon_w;
  logic [31:0] mon_a;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every new burst request and every popped head word against the queues.
  always @(negedge clk) begin
    if (bus.rd_burst_req && !req_prev) begin
      if (exp_addr.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_req: got request at %0h want no request", bus.rd_burst_addr);
      end else begin
        mon_a = exp_addr.pop_front();
        check("burst_addr", 64'(bus.rd_burst_addr), 64'(mon_a));
      end
    end
    req_prev = bus.rd_burst_req;
    if (bus.i_weight_valid && exp_word.size() > 0) begin
      mon_w = exp_word.pop_front();
      check("pop_data", bus.o_weight_out, mon_w.data);
      check("pop_seg",  64'(bus.o_weight_seg),  64'(mon_w.seg));
      check("pop_last", 64'(bus.o_weight_last), 64'(mon_w.last));
    end
  end

  // DDR model for one burst at eaddr: nbeats valid words then a finish pulse.
  task automatic serve(input logic [31:0] eaddr, input int nbeats, input bit flush_mid,
                       input bit pop_along, input bit flush_fin);
    int    n;
    bit    dropping;
    word_t w;
    n = 0;
    dropping = 1'b0;
    while (bus.rd_burst_req !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    if (bus.rd_burst_req !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL req_timeout: req low after %0d cycles, want request for %0h", n, eaddr);
      return;
    end
    for (int b = 0; b < nbeats; b++) begin
      if (flush_mid && b == 2) begin
        bus.rd_burst_valid = 1'b0;
        bus.load_w_finish  = 1'b1;
        tick();
        bus.load_w_finish  = 1'b0;
        exp_word.delete();
        dropping = 1'b1;
      end
      bus.rd_burst_valid = 1'b1;
      bus.rd_burst_data  = {eaddr, 32'(b)};
      bus.i_weight_valid = pop_along;
      if (!dropping && b < 4) begin
        w.data = {eaddr, 32'(b)};
        w.seg  = (eaddr == 32'h1040);
        w.last = (b == 3) && (eaddr == 32'h1020 || eaddr == 32'h1040);
        exp_word.push_back(w);
      end
      tick();
      if (pop_along) check("ready_concurrent", 64'(bus.o_weight_ready), 64'd1);
      else if (!dropping && b < 4)
        check("ready_level", 64'(bus.o_weight_ready), 64'(exp_word.size() >= 4));
    end
    bus.rd_burst_valid  = 1'b0;
    bus.i_weight_valid  = 1'b0;
    bus.rd_burst_finish = 1'b1;
    bus.load_w_finish   = flush_fin;
    if (flush_fin) exp_word.delete();
    tick();
    bus.rd_burst_finish = 1'b0;
    bus.load_w_finish   = 1'b0;
    check("req_low_after_finish", 64'(bus.rd_burst_req), 64'd0);
  endtask

  task automatic pop_n(input int n);
    bus.i_weight_valid = 1'b1;
    repeat (n) tick();
    bus.i_weight_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rd_burst_data   = '0;
    bus.rd_burst_valid  = 1'b0;
    bus.rd_burst_finish = 1'b0;
    bus.i_weight_valid  = 1'b0;
    bus.load_w_finish   = 1'b0;
    repeat (3) tick();

    check("rst_req",   64'(bus.rd_burst_req),   64'd0);
    check("rst_addr",  64'(bus.rd_burst_addr),  64'h1000);
    check("rst_len",   64'(bus.rd_burst_len),   64'd4);
    check("rst_out",   bus.o_weight_out,        64'd0);
    check("rst_seg",   64'(bus.o_weight_seg),   64'd0);
    check("rst_last",  64'(bus.o_weight_last),  64'd0);
    check("rst_ready", 64'(bus.o_weight_ready), 64'd0);
    check("rst_err",   64'(bus.o_err),          64'd0);

    // Fill with no pops: seg0 pass0, seg0 pass1, then buffer full at 16 words.
    exp_addr.push_back(32'h1000);
    exp_addr.push_back(32'h1020);
    exp_addr.push_back(32'h1000);
    exp_addr.push_back(32'h1020);
    rst = 1'b0;
    serve(32'h1000, 4, 1'b0, 1'b0, 1'b0);
    serve(32'h1020, 4, 1'b0, 1'b0, 1'b0);
    serve(32'h1000, 4, 1'b0, 1'b0, 1'b0);
    serve(32'h1020, 4, 1'b0, 1'b0, 1'b0);
    check("next_addr_seg1", 64'(bus.rd_burst_addr), 64'h1040);
    repeat (8) tick();
    check("stall_full_req", 64'(bus.rd_burst_req),   64'd0);
    check("ready_full",     64'(bus.o_weight_ready), 64'd1);

    // Pop 4 frees one burst of space: segment 1 is fetched, pointer wraps to seg0.
    exp_addr.push_back(32'h1040);
    pop_n(4);
    serve(32'h1040, 4, 1'b0, 1'b0, 1'b0);
    check("next_addr_wrap", 64'(bus.rd_burst_addr), 64'h1000);

    // Drain everything, then refill from empty and watch ready rise at 4 words.
    exp_addr.push_back(32'h1000);
    exp_addr.push_back(32'h1020);
    pop_n(16);
    check("drain_empty_out",   bus.o_weight_out,        64'd0);
    check("drain_empty_ready", 64'(bus.o_weight_ready), 64'd0);
    serve(32'h1000, 4, 1'b0, 1'b0, 1'b0);

    // Concurrent push and pop at count 4.
    serve(32'h1020, 4, 1'b0, 1'b1, 1'b0);
    check("ready_after_concurrent", 64'(bus.o_weight_ready), 64'd1);

    // Flush mid-burst after 2 words; restart at the base address.
    exp_addr.push_back(32'h1000);
    exp_addr.push_back(32'h1000);
    serve(32'h1000, 4, 1'b1, 1'b0, 1'b0);
    tick();
    check("flush_err",   64'(bus.o_err),          64'd0);
    check("flush_out",   bus.o_weight_out,        64'd0);
    check("flush_ready", 64'(bus.o_weight_ready), 64'd0);

    // Pop on empty buffer.
    bus.i_weight_valid = 1'b1;
    tick();
    bus.i_weight_valid = 1'b0;
    check("underflow_err", 64'(bus.o_err),   64'd1);
    check("underflow_out", bus.o_weight_out, 64'd0);

    // Finish and flush together: flush wins and clears the error.
    exp_addr.push_back(32'h1000);
    serve(32'h1000, 0, 1'b0, 1'b0, 1'b1);
    tick();
    check("flush_clears_err", 64'(bus.o_err), 64'd0);

    // Five-beat burst: only four stored, overflow flagged.
    exp_addr.push_back(32'h1020);
    serve(32'h1000, 5, 1'b0, 1'b0, 1'b0);
    check("overflow_err", 64'(bus.o_err), 64'd1);
    pop_n(4);
    check("overflow_only4", bus.o_weight_out, 64'd0);

    // Reset in the middle of a burst, then a stale beat right after reset.
    bus.rd_burst_valid = 1'b1;
    bus.rd_burst_data  = 64'hDEAD_BEEF_0000_0001;
    repeat (2) tick();
    bus.rd_burst_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    exp_word.delete();
    check("mid_reset_req", 64'(bus.rd_burst_req), 64'd0);
    check("mid_reset_err", 64'(bus.o_err),        64'd0);
    exp_addr.push_back(32'h1000);
    rst = 1'b0;
    bus.rd_burst_valid = 1'b1;
    tick();
    bus.rd_burst_valid = 1'b0;
    check("stale_valid_err", 64'(bus.o_err),   64'd1);
    check("stale_valid_out", bus.o_weight_out, 64'd0);
    repeat (3) tick();
    check("addr_queue_empty", 64'(exp_addr.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
